// File: rtl/uart_tx.sv
// Byte-serial UART transmitter (8N1/8N2) paced by an external baud strobe.
// A one-entry holding buffer lets the next byte queue so frames go out back to back.
module uart_tx #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic       BAUD_EN,
  input  logic [7:0] DATA,
  input  logic       VALID,
  output logic       READY,
  output logic       TX,
  output logic       BUSY
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned STOP_W = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   hold_q;
  logic                hold_full_q;
  logic [DATA_W-1:0]   shift_q;
  logic [IDX_W-1:0]    idx_q;
  logic [STOP_W-1:0]   stop_cnt_q;

  logic accept;
  logic stop_done;
  logic load;

  // READY mirrors the empty buffer, so an accept can never coincide with a load.
  assign accept    = VALID & READY;
  assign stop_done = (32'(stop_cnt_q) + 32'd1) >= STOP_BITS;
  assign load      = BAUD_EN & hold_full_q &
                     ((state_q == S_IDLE) | ((state_q == S_STOP) & stop_done));

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      stop_cnt_q  <= '0;
      READY       <= 1'b1;
      TX          <= 1'b1;
      BUSY        <= 1'b0;
    end else begin
      if (load) begin
        shift_q     <= hold_q;
        hold_full_q <= 1'b0;
        READY       <= 1'b1;
        TX          <= 1'b0;
        state_q     <= S_START;
      end else if (BAUD_EN) begin
        case (state_q)
          S_IDLE: begin
            TX <= 1'b1;
          end
          S_START: begin
            TX      <= shift_q[0];
            idx_q   <= '0;
            state_q <= S_DATA;
          end
          S_DATA: begin
            shift_q <= {1'b0, shift_q[DATA_W-1:1]};
            if (idx_q != IDX_W'(DATA_W - 1)) begin
              TX    <= shift_q[1];
              idx_q <= idx_q + IDX_W'(1);
            end else begin
              TX         <= 1'b1;
              stop_cnt_q <= '0;
              state_q    <= S_STOP;
            end
          end
          S_STOP: begin
            if (!stop_done) begin
              stop_cnt_q <= stop_cnt_q + STOP_W'(1);
            end else begin
              state_q <= S_IDLE;
              BUSY    <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            TX      <= 1'b1;
          end
        endcase
      end

      // Placed last so a same-edge accept keeps BUSY high as the frame ends.
      if (accept) begin
        hold_q      <= DATA;
        hold_full_q <= 1'b1;
        READY       <= 1'b0;
        BUSY        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; one instance per stop-bit setting.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] baud_cnt = 4'd0;
  logic       baud_hi = 1'b0;
  logic       baud_en;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       sel2 = 1'b0;

  logic ready1, tx1, busy1;
  logic ready2, tx2, busy2;
  logic cur_ready, cur_tx, cur_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Nominal strobe: carry-out of a free-running 4-bit counter.
  always @(posedge clk) baud_cnt <= baud_cnt + 4'd1;
  assign baud_en = baud_hi | (baud_cnt == 4'd15);

  assign cur_ready = sel2 ? ready2 : ready1;
  assign cur_tx    = sel2 ? tx2    : tx1;
  assign cur_busy  = sel2 ? busy2  : busy1;

  uart_tx #(.STOP_BITS(1)) u_dut1 (
    .CLKIN   (clk),
    .RESETN  (rst_n),
    .BAUD_EN (baud_en),
    .DATA    (data),
    .VALID   (valid & ~sel2),
    .READY   (ready1),
    .TX      (tx1),
    .BUSY    (busy1)
  );

  uart_tx #(.STOP_BITS(2)) u_dut2 (
    .CLKIN   (clk),
    .RESETN  (rst_n),
    .BAUD_EN (baud_en),
    .DATA    (data),
    .VALID   (valid & sel2),
    .READY   (ready2),
    .TX      (tx2),
    .BUSY    (busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [7:0] d);
    bit done;
    done  = 1'b0;
    data  = d;
    valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      if (cur_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    check("accept", 32'(done), 32'd1);
  endtask

  // Checks every cycle of a frame; blen is cycles per bit interval.
  task automatic check_frame(input logic [7:0] d, input int blen, input bit immediate,
                             input bit chk_ready);
    logic [10:0] bits;
    int          nb;
    bit          found;
    bits  = {2'b11, d, 1'b0};
    nb    = sel2 ? 11 : 10;
    found = immediate;
    for (int i = 0; i < 200 && !found; i++) begin
      if (cur_tx == 1'b0) begin
        found = 1'b1;
      end else begin
        if (chk_ready) check("ready_low_until_start", 32'(cur_ready), 32'd0);
        @(negedge clk);
      end
    end
    if (!immediate) check("start_seen", 32'(found), 32'd1);
    if (found) begin
      if (chk_ready) check("ready_at_start", 32'(cur_ready), 32'd1);
      for (int b = 0; b < nb; b++) begin
        for (int c = 0; c < blen; c++) begin
          check($sformatf("tx_bit%0d_cyc%0d", b, c), 32'(cur_tx), 32'(bits[b]));
          if (b == nb - 1 && c == blen - 1) check("busy_in_stop", 32'(cur_busy), 32'd1);
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    32'(cur_tx),    32'd1);
    check({tag, "_ready"}, 32'(cur_ready), 32'd1);
    check({tag, "_busy"},  32'(cur_busy),  32'd0);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst_n = 1'b1;

    // Idle with strobes running and no data.
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check_idle("idle");
    end

    // Single frame 0x55.
    send(8'h55);
    check("ready_after_accept", 32'(cur_ready), 32'd0);
    check("busy_after_accept",  32'(cur_busy),  32'd1);
    check_frame(8'h55, 16, 1'b0, 1'b1);
    check("busy_after_frame", 32'(cur_busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("tx_idle_after", 32'(cur_tx), 32'd1);
      @(negedge clk);
    end

    // Back-to-back 0xA5 then 0x3C.
    send(8'hA5);
    fork
      begin
        check_frame(8'hA5, 16, 1'b0, 1'b0);
        check_frame(8'h3C, 16, 1'b1, 1'b0);
      end
      send(8'h3C);
    join
    check("busy_after_b2b", 32'(cur_busy), 32'd0);

    // DATA changed to 0xFF while buffer full must not corrupt 0x12.
    send(8'h12);
    fork
      begin
        check_frame(8'h12, 16, 1'b0, 1'b0);
        check_frame(8'hFF, 16, 1'b1, 1'b0);
      end
      send(8'hFF);
    join
    check("busy_after_ff", 32'(cur_busy), 32'd0);

    // Reset in the middle of data bit 3 of 0x00.
    send(8'h00);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (cur_tx == 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_start_seen", 32'(found), 32'd1);
    repeat (16 * 4 + 8) @(negedge clk);
    check("d3_low", 32'(cur_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    send(8'h81);
    check_frame(8'h81, 16, 1'b0, 1'b1);
    check("busy_after_81", 32'(cur_busy), 32'd0);

    // Continuous strobe: one bit per clock.
    baud_hi = 1'b1;
    send(8'h0F);
    check_frame(8'h0F, 1, 1'b0, 1'b1);
    check("busy_after_fast", 32'(cur_busy), 32'd0);
    baud_hi = 1'b0;
    repeat (4) @(negedge clk);

    // Two stop bits, 0x00 twice back to back: 32 high cycles between frames.
    sel2 = 1'b1;
    @(negedge clk);
    check_idle("sb2_idle");
    send(8'h00);
    fork
      begin
        check_frame(8'h00, 16, 1'b0, 1'b0);
        check_frame(8'h00, 16, 1'b1, 1'b0);
      end
      send(8'h00);
    join
    check("busy_after_sb2", 32'(cur_busy), 32'd0);
    sel2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
